// File: rtl/snake_arith_pkg.sv
// rtl/snake_arith_pkg.sv - shared types, defaults and sizing helpers for the snake arithmetic blocks
//
// Purpose: state encoding for the chunked add/sub sequencer, default datapath
//          geometry, and helpers that derive the step count and step-counter
//          width from WIDTH/CHUNK.
// Ports:   none (package).
package snake_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arithState_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  // Returns 0 for an illegal geometry so the user can reject it at elaboration.
  function automatic int calcSteps(input int width, input int chunk);
    if (chunk <= 0 || width <= 0 || (width % chunk) != 0) begin
      return 0;
    end
    return width / chunk;
  endfunction

  // The step counter is never narrower than one bit, even for a single-step add.
  function automatic int stepWidth(input int nSteps);
    return (nSteps > 1) ? $clog2(nSteps) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit adder slice with carry-into-MSB tap
//
// Purpose: adds one chunk of the operands plus an incoming carry.
// Ports:
//   a, b          in  CHUNK  operand slices
//   cin           in  1      carry in
//   sum           out CHUNK  slice result
//   cout          out 1      carry out of the slice MSB
//   carryIntoMsb  out 1      carry into the slice MSB (for signed overflow)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             carryIntoMsb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum  = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // sum[msb] = a[msb] ^ b[msb] ^ c_in_msb, so the carry into the MSB falls out
  // of the sum bit without a separate narrower adder.
  assign carryIntoMsb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// rtl/chunked_addsub.sv - multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per cycle
//
// Purpose: accepts A, B and an add/sub select over a valid/ready handshake,
//          ripples the operation through CHUNK-bit slices with a registered
//          carry, then holds the result until the consumer takes it.
// Optional: define CHUNKED_ADDSUB_SATURATE_EN to clamp the final sum on signed
//          overflow (flags are still reported unchanged).
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      operands and op present
//   in_ready   out 1      idle, can accept an operation
//   a, b       in  WIDTH  operands
//   sub        in  1      0 = A+B, 1 = A-B
//   out_valid  out 1      result valid
//   out_ready  in  1      consumer takes the result
//   sum        out WIDTH  result (modulo 2^WIDTH)
//   carry_out  out 1      carry out of MSB; for sub, 1 = no borrow
//   overflow   out 1      signed two's-complement overflow
module chunked_addsub
  import snake_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSTEPS = calcSteps(WIDTH, CHUNK);
  localparam int STEP_W = stepWidth(NSTEPS);

  generate
    if (NSTEPS == 0) begin : gBadGeometry
      $error("chunked_addsub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  arithState_t state, nextState;

  logic [WIDTH-1:0]  aReg;
  logic [WIDTH-1:0]  bReg;
  logic [WIDTH-1:0]  sumReg;
  logic              carryReg;
  logic              carryOutReg;
  logic              overflowReg;
  logic [STEP_W-1:0] step;

  logic [CHUNK-1:0]  chunkA;
  logic [CHUNK-1:0]  chunkB;
  logic [CHUNK-1:0]  chunkSum;
  logic              chunkCout;
  logic              chunkCarryMsb;
  logic              lastStep;
  logic              finalOverflow;

  assign chunkA        = aReg[int'(step)*CHUNK +: CHUNK];
  assign chunkB        = bReg[int'(step)*CHUNK +: CHUNK];
  assign lastStep      = (step == STEP_W'(NSTEPS - 1));
  assign finalOverflow = chunkCarryMsb ^ chunkCout;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) uChunkAdder (
    .a            (chunkA),
    .b            (chunkB),
    .cin          (carryReg),
    .sum          (chunkSum),
    .cout         (chunkCout),
    .carryIntoMsb (chunkCarryMsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (in_valid) nextState = RUN;
      RUN:     if (lastStep) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aReg        <= '0;
      bReg        <= '0;
      sumReg      <= '0;
      carryReg    <= 1'b0;
      carryOutReg <= 1'b0;
      overflowReg <= 1'b0;
      step        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B once here, seed the carry with sub.
            aReg     <= a;
            bReg     <= b ^ {WIDTH{sub}};
            carryReg <= sub;
            step     <= '0;
          end
        end
        RUN: begin
          sumReg[int'(step)*CHUNK +: CHUNK] <= chunkSum;
          carryReg <= chunkCout;
          if (lastStep) begin
            carryOutReg <= chunkCout;
            overflowReg <= finalOverflow;
`ifdef CHUNKED_ADDSUB_SATURATE_EN
            // Overflow can only happen when both inputs share a sign, so A's
            // sign picks the rail.
            if (finalOverflow) begin
              sumReg <= aReg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
          end else begin
            step <= step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sumReg;
  assign carry_out = carryOutReg;
  assign overflow  = overflowReg;

endmodule
